wolfram_ca_engine: RTL and testbench
====================================

Name: wolfram_ca_engine

Overview:
Parametrised successor to the fixed 3-input Wolfram-rule gates. The 8-bit rule is a runtime register, and the block applies it across a WIDTH-cell one-dimensional cellular automaton, one generation per clock. The user loads an initial state, writes a rule and requests N generations. The block sequences the run and reports completion; it serves as a programmable rule-evaluation core for circuit-compilation experiments.

Parameters:
WIDTH, 16, number of cells (>= 3)
GEN_W, 8, width of the generation count and counter
RULE_DEFAULT, 8'h73, rule register value after reset
BOUNDARY, 1, edge handling: 0 = null (out-of-range neighbours read 0), 1 = periodic (wrap-around)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
load_valid  input  1  initial-state load request
load_ready  output  1  load accepted this cycle when high with load_valid
load_state  input  WIDTH  initial cell values
rule_we  input  1  rule register write strobe
rule_in  input  8  new rule value
start  input  1  run request (single-cycle sample)
gens  input  GEN_W  generations to apply, sampled with start
busy  output  1  high in RUN
done  output  1  high in DONE
fixpoint  output  1  run ended on a stable state (macro-dependent)
state_out  output  WIDTH  current cell register
gen_count  output  GEN_W  generations applied in current/last run

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset (synchronous, any state including mid-RUN) sets the following: FSM=IDLE, state_out=0, rule=RULE_DEFAULT, gen_count=0, busy=0, done=0, fixpoint=0.
- Cell i update: l=cell[i+1], c=cell[i], r=cell[i-1]. Bit WIDTH-1 is the leftmost cell.
- Next-state rule: next[i] = rule[7 - {l,c,r}]. With rule 0x73: 000→0, 001→1, 010→1, 011→1, 100→0, 101→0, 110→1, 111→1.
- Edges: cell[WIDTH] and cell[-1] read cell[0] and cell[WIDTH-1] when BOUNDARY=1, and read 0 when BOUNDARY=0.
- FSM states: IDLE, RUN, DONE.
- load_ready = !busy. In IDLE or DONE, load_valid sets state_out<=load_state and gen_count<=0. In DONE a load also moves the FSM to IDLE and clears done and fixpoint.
- rule_we writes the rule in IDLE and DONE. It is ignored in RUN, so the rule stays constant for a whole run.
- start in IDLE or DONE:
  - Latches gens and sets gen_count<=0.
  - gens==0: go to DONE next edge, done=1, state unchanged.
  - Otherwise: go to RUN.
  - start is ignored in RUN.
- Simultaneous load_valid and start (IDLE/DONE): the load applies first, and the run starts from the loaded state.
- Simultaneous rule_we and start: the new rule is used for the run.
- RUN, each edge: state_out<=next(state_out) and gen_count<=gen_count+1. When gen_count+1 == latched gens, go to DONE.
- Latency: N generations occupy N RUN cycles. done rises on the Nth edge after the start-sampling edge and is held until the next start or load.
- gen_count never wraps. The maximum run is 2^GEN_W-1 generations.
- busy is registered, with busy=1 exactly while in RUN.

Optional Feature:
Macro: WOLFRAM_CA_FIXPOINT_STOP_EN
- Defined: in RUN, if next(state_out)==state_out, that edge increments gen_count, moves to DONE and sets fixpoint=1, even if fewer than gens generations have elapsed.
- Not defined: runs always complete all gens generations, and fixpoint is tied to 0.

Test Plan:
- Reset value: reset, then idle → state_out=0, busy=0, done=0, and a rule readback via gens=1 on load 0x01 (WIDTH=8) gives 0x03, confirming RULE_DEFAULT=0x73.
- Single step (WIDTH=8, BOUNDARY=1): load 0x01, start gens=2 → 0x03 after edge 1, 0x07 after edge 2; done=1 with gen_count=2; busy high exactly 2 cycles.
- Rule write: rule_we rule_in=0x00, load 0xA5, start gens=1 → state_out=0x00. Then rule 0xFF, gens=1 → 0xFF. A rule_we issued during a gens=5 RUN has no effect.
- Fixpoint: rule 0x73, load 0x01, gens=10 → state 0x7F after 6 generations. With the macro: done after 7, gen_count=7, fixpoint=1. Without: done after 10, gen_count=10, fixpoint=0.
- Edge cases: start with gens=0 → DONE next edge, state unchanged. load_valid+start in the same cycle runs from the new state. reset asserted mid-RUN → IDLE, state 0, rule 0x73 next edge.
- Boundary: WIDTH=8, rule 0x73, load 0x80, gens=1 → 0x80 with BOUNDARY=0 and 0x81 with BOUNDARY=1.

Source files
------------

// File: rtl/wolfram_ca_engine.sv
`default_nettype none
// ============================================================================
// Module   : wolfram_ca_engine
// Purpose  : runtime-programmable Wolfram-rule 1-D cellular automaton engine,
//            one generation per clock. Optional macro: WOLFRAM_CA_FIXPOINT_STOP_EN
// Revision : 1.0
// ============================================================================
module wolfram_ca_engine #(
  parameter int         WIDTH        = 16,
  parameter int         GEN_W        = 8,
  parameter logic [7:0] RULE_DEFAULT = 8'h73,
  parameter int         BOUNDARY     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_state,
  input  logic             rule_we,
  input  logic [7:0]       rule_in,
  input  logic             start,
  input  logic [GEN_W-1:0] gens,
  output logic             busy,
  output logic             done,
  output logic             fixpoint,
  output logic [WIDTH-1:0] state_out,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [GEN_W-1:0] c_gen_one  = {{(GEN_W-1){1'b0}}, 1'b1};
  localparam logic [GEN_W-1:0] c_gen_zero = '0;

  state_t           r_state;
  logic [WIDTH-1:0] r_cells;
  logic [7:0]       r_rule;
  logic [GEN_W-1:0] r_gens;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_busy;
  logic             r_done;
  logic             r_fixpoint;

  logic [WIDTH+1:0] w_ext;
  logic [WIDTH-1:0] w_next;
  logic [GEN_W-1:0] w_gen_inc;
  logic             w_last;
  logic             w_stop;
  logic             w_fix_hit;

  // Pad the cell row with one virtual neighbour on each side.
  assign w_ext = {(BOUNDARY != 0) ? r_cells[0] : 1'b0,
                  r_cells,
                  (BOUNDARY != 0) ? r_cells[WIDTH-1] : 1'b0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic [2:0] w_nbr;
    assign w_nbr      = w_ext[gi+2:gi];
    assign w_next[gi] = r_rule[3'd7 - w_nbr];
  end

  assign w_gen_inc = r_gen_count + c_gen_one;
  assign w_last    = (w_gen_inc == r_gens);

`ifdef WOLFRAM_CA_FIXPOINT_STOP_EN
  logic w_stable;
  assign w_stable  = (w_next == r_cells);
  assign w_stop    = w_last | w_stable;
  assign w_fix_hit = w_stable;
`else
  assign w_stop    = w_last;
  assign w_fix_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cells     <= '0;
      r_rule      <= RULE_DEFAULT;
      r_gens      <= '0;
      r_gen_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fixpoint  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (rule_we) r_rule <= rule_in;
          if (load_valid) begin
            r_cells     <= load_state;
            r_gen_count <= '0;
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_fixpoint  <= 1'b0;
          end
          // A start in the same cycle overrides the load's IDLE transition;
          // the run then begins from the freshly loaded cells.
          if (start) begin
            r_gens      <= gens;
            r_gen_count <= '0;
            r_fixpoint  <= 1'b0;
            if (gens == c_gen_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_cells     <= w_next;
          r_gen_count <= w_gen_inc;
          if (w_stop) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_fixpoint <= w_fix_hit;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = ~r_busy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fixpoint   = r_fixpoint;
  assign state_out  = r_cells;
  assign gen_count  = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_wolfram_ca_engine.sv
`default_nettype none
// Bench for wolfram_ca_engine: two WIDTH=8 instances (periodic and null edges)
// driven in lockstep, checked against a vector table and a rule-level model.
module tb_wolfram_ca_engine;

  localparam int W = 8;
  localparam int G = 8;
`ifdef WOLFRAM_CA_FIXPOINT_STOP_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, load_valid, rule_we, start;
  logic [W-1:0] load_state;
  logic [7:0]   rule_in;
  logic [G-1:0] gens;

  logic         b1_ready, b1_busy, b1_done, b1_fix;
  logic [W-1:0] b1_state;
  logic [G-1:0] b1_gc;
  logic         b0_ready, b0_busy, b0_done, b0_fix;
  logic [W-1:0] b0_state;
  logic [G-1:0] b0_gc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wolfram_ca_engine #(.WIDTH(W), .GEN_W(G), .RULE_DEFAULT(8'h73), .BOUNDARY(1)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(b1_ready),
    .load_state(load_state), .rule_we(rule_we), .rule_in(rule_in), .start(start),
    .gens(gens), .busy(b1_busy), .done(b1_done), .fixpoint(b1_fix),
    .state_out(b1_state), .gen_count(b1_gc));

  wolfram_ca_engine #(.WIDTH(W), .GEN_W(G), .RULE_DEFAULT(8'h73), .BOUNDARY(0)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(b0_ready),
    .load_state(load_state), .rule_we(rule_we), .rule_in(rule_in), .start(start),
    .gens(gens), .busy(b0_busy), .done(b0_done), .fixpoint(b0_fix),
    .state_out(b0_state), .gen_count(b0_gc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each cell looks up rule bit 7-(4l+2c+r).
  function automatic logic [W-1:0] step(input logic [W-1:0] s, input logic [7:0] rule,
                                         input bit periodic);
    logic [W-1:0] n;
    int l, c, r, idx;
    for (int i = 0; i < W; i++) begin
      if (i == W-1) l = periodic ? int'(s[0]) : 0;
      else          l = int'(s[i+1]);
      c = int'(s[i]);
      if (i == 0)   r = periodic ? int'(s[W-1]) : 0;
      else          r = int'(s[i-1]);
      idx  = 4*l + 2*c + r;
      n[i] = rule[7-idx];
    end
    return n;
  endfunction

  task automatic ref_run(input logic [W-1:0] ld, input logic [7:0] rule, input int n,
                         input bit periodic, output logic [W-1:0] st, output int gc,
                         output bit fix);
    logic [W-1:0] nx;
    st = ld; gc = 0; fix = 1'b0;
    for (int k = 0; k < n; k++) begin
      nx = step(st, rule, periodic);
      gc++;
      if (FP && nx == st) begin
        fix = 1'b1;
        break;
      end
      st = nx;
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!(b1_done && b0_done) && cyc < 600) begin
      tick();
      cyc++;
    end
    chk("done_timeout", {31'd0, b1_done && b0_done}, 32'd1);
  endtask

  task automatic run(input bit wr, input logic [7:0] rule, input logic [W-1:0] ld,
                     input logic [G-1:0] n);
    rule_we = wr; rule_in = rule; load_valid = 1'b1; load_state = ld;
    tick();
    rule_we = 1'b0; load_valid = 1'b0;
    start = 1'b1; gens = n;
    tick();
    start = 1'b0;
    wait_done();
  endtask

  typedef struct {
    bit           wr;
    logic [7:0]   rule;
    logic [W-1:0] ld;
    logic [G-1:0] n;
    logic [W-1:0] e1;
    logic [W-1:0] e0;
    logic [G-1:0] egc;
    bit           efix;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [W-1:0] rst1, rst0;
    int           rgc1, rgc0;
    bit           rfx1, rfx0;
    int           busy_cyc;

    // First entry relies on the reset rule (no write) to read back 0x73.
    vt.push_back('{1'b0, 8'h00, 8'h01, 8'd1,  8'h03, 8'h03, 8'd1, 1'b0});
    vt.push_back('{1'b1, 8'h73, 8'h01, 8'd2,  8'h07, 8'h07, 8'd2, 1'b0});
    vt.push_back('{1'b1, 8'h00, 8'hA5, 8'd1,  8'h00, 8'h00, 8'd1, 1'b0});
    vt.push_back('{1'b1, 8'hFF, 8'hA5, 8'd1,  8'hFF, 8'hFF, 8'd1, 1'b0});
    vt.push_back('{1'b1, 8'h73, 8'h80, 8'd1,  8'h81, 8'h80, 8'd1, 1'b0});
    vt.push_back('{1'b1, 8'h73, 8'h01, 8'd10, 8'h7F, 8'hFF, FP ? 8'd7 : 8'd10, FP});
    vt.push_back('{1'b1, 8'h00, 8'h00, 8'd3,  8'h00, 8'h00, FP ? 8'd1 : 8'd3,  FP});

    reset = 1'b1; load_valid = 1'b0; rule_we = 1'b0; start = 1'b0;
    load_state = '0; rule_in = '0; gens = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", {24'd0, b1_state}, 32'd0);
    chk("rst_busy",  {31'd0, b1_busy}, 32'd0);
    chk("rst_done",  {31'd0, b1_done}, 32'd0);
    chk("rst_fix",   {31'd0, b1_fix}, 32'd0);
    chk("rst_gc",    {24'd0, b1_gc}, 32'd0);
    chk("rst_ready", {31'd0, b1_ready}, 32'd1);

    foreach (vt[k]) begin
      run(vt[k].wr, vt[k].rule, vt[k].ld, vt[k].n);
      chk($sformatf("vec%0d_state_p", k), {24'd0, b1_state}, {24'd0, vt[k].e1});
      chk($sformatf("vec%0d_state_n", k), {24'd0, b0_state}, {24'd0, vt[k].e0});
      chk($sformatf("vec%0d_gc", k),      {24'd0, b1_gc}, {24'd0, vt[k].egc});
      chk($sformatf("vec%0d_fix", k),     {31'd0, b1_fix}, {31'd0, vt[k].efix});
      chk($sformatf("vec%0d_busy", k),    {31'd0, b1_busy}, 32'd0);
    end

    // Cycle-by-cycle two-generation run with busy duration.
    rule_we = 1'b1; rule_in = 8'h73; load_valid = 1'b1; load_state = 8'h01;
    tick();
    rule_we = 1'b0; load_valid = 1'b0;
    chk("ss_done_cleared", {31'd0, b1_done}, 32'd0);
    start = 1'b1; gens = 8'd2;
    tick();
    start = 1'b0;
    busy_cyc = 0;
    chk("ss_e0_state", {24'd0, b1_state}, 32'h01);
    chk("ss_e0_ready", {31'd0, b1_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (b1_busy) busy_cyc++;
      tick();
      if (c == 0) begin
        chk("ss_e1_state", {24'd0, b1_state}, 32'h03);
        chk("ss_e1_gc",    {24'd0, b1_gc}, 32'd1);
        chk("ss_e1_done",  {31'd0, b1_done}, 32'd0);
      end
      if (c == 1) begin
        chk("ss_e2_state", {24'd0, b1_state}, 32'h07);
        chk("ss_e2_done",  {31'd0, b1_done}, 32'd1);
        chk("ss_e2_gc",    {24'd0, b1_gc}, 32'd2);
      end
    end
    chk("ss_busy_cycles", busy_cyc, 32'd2);
    chk("ss_done_held", {31'd0, b1_done}, 32'd1);

    // Rule write and start issued mid-run are both ignored.
    rule_we = 1'b1; rule_in = 8'h73; load_valid = 1'b1; load_state = 8'h01;
    tick();
    rule_we = 1'b0; load_valid = 1'b0; start = 1'b1; gens = 8'd5;
    tick();
    start = 1'b0;
    tick();
    rule_we = 1'b1; rule_in = 8'h00; start = 1'b1; gens = 8'd2;
    tick();
    rule_we = 1'b0; start = 1'b0;
    wait_done();
    chk("runwr_state", {24'd0, b1_state}, 32'h3F);
    chk("runwr_gc",    {24'd0, b1_gc}, 32'd5);
    run(1'b0, 8'h00, 8'h01, 8'd1);
    chk("runwr_rule_kept", {24'd0, b1_state}, 32'h03);

    // gens == 0 finishes on the next edge with the state untouched.
    rule_we = 1'b0; load_valid = 1'b1; load_state = 8'hA5;
    tick();
    load_valid = 1'b0; start = 1'b1; gens = 8'd0;
    tick();
    start = 1'b0;
    chk("g0_done",  {31'd0, b1_done}, 32'd1);
    chk("g0_busy",  {31'd0, b1_busy}, 32'd0);
    chk("g0_state", {24'd0, b1_state}, 32'hA5);
    chk("g0_gc",    {24'd0, b1_gc}, 32'd0);

    // Load, rule write and start all in one cycle.
    rule_we = 1'b1; rule_in = 8'hFF; load_valid = 1'b1; load_state = 8'h00;
    start = 1'b1; gens = 8'd1;
    tick();
    rule_we = 1'b0; load_valid = 1'b0; start = 1'b0;
    wait_done();
    chk("same_cyc_state", {24'd0, b1_state}, 32'hFF);
    chk("same_cyc_gc",    {24'd0, b1_gc}, 32'd1);

    // Reset in the middle of a run.
    rule_we = 1'b1; rule_in = 8'h73; load_valid = 1'b1; load_state = 8'h01;
    tick();
    rule_we = 1'b0; load_valid = 1'b0; start = 1'b1; gens = 8'd20;
    tick();
    start = 1'b0;
    rule_we = 1'b1; rule_in = 8'h00;
    tick(); tick();
    chk("mid_busy", {31'd0, b1_busy}, 32'd1);
    rule_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", {24'd0, b1_state}, 32'd0);
    chk("mid_rst_busy",  {31'd0, b1_busy}, 32'd0);
    chk("mid_rst_done",  {31'd0, b1_done}, 32'd0);
    chk("mid_rst_gc",    {24'd0, b1_gc}, 32'd0);
    run(1'b0, 8'h00, 8'h01, 8'd1);
    chk("mid_rst_rule", {24'd0, b1_state}, 32'h03);

    // Randomised runs against the rule-level model.
    for (int t = 0; t < 25; t++) begin
      logic [7:0]   rr;
      logic [W-1:0] ll;
      int           nn;
      rr = 8'($urandom);
      ll = W'($urandom);
      nn = (t % 6 == 0) ? 0 : int'($urandom_range(1, 40));
      run(1'b1, rr, ll, G'(nn));
      ref_run(ll, rr, nn, 1'b1, rst1, rgc1, rfx1);
      ref_run(ll, rr, nn, 1'b0, rst0, rgc0, rfx0);
      chk($sformatf("rnd%0d_state_p", t), {24'd0, b1_state}, {24'd0, rst1});
      chk($sformatf("rnd%0d_state_n", t), {24'd0, b0_state}, {24'd0, rst0});
      chk($sformatf("rnd%0d_gc_p", t),    {24'd0, b1_gc}, rgc1);
      chk($sformatf("rnd%0d_gc_n", t),    {24'd0, b0_gc}, rgc0);
      chk($sformatf("rnd%0d_fix_p", t),   {31'd0, b1_fix}, {31'd0, rfx1});
      chk($sformatf("rnd%0d_fix_n", t),   {31'd0, b0_fix}, {31'd0, rfx0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
